// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control sequencer: state encoding,
// instruction opcodes and IR field positions.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;
  localparam int REG_IDX_W = RA_MSB - RA_LSB + 1;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SHR) || (op == OP_SHL);
  endfunction

  function automatic logic is_muldiv_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// Register-index to one-hot strobe decoder; all outputs low when disabled.
module reg_field_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int NUM_OUT = 16,
  parameter int SEL_W   = REG_IDX_W
) (
  input  logic               en,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch (T0-T2), register ALU execute (T3-T5) and
// mul/div execute (T3-T6), with a sticky stop request that halts at instruction end.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] IR,
  input  logic                  stop,
  output logic                  PCout,
  output logic                  Zlo_out,
  output logic                  Zhi_out,
  output logic                  MDRout,
  output logic                  MARin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  Zin,
  output logic                  HIin,
  output logic                  LOin,
  output logic                  IncPC,
  output logic                  Read,
  output logic [NUM_REGS-1:0]   Rin,
  output logic [NUM_REGS-1:0]   Rout,
  output logic [4:0]            opcode,
  output logic                  run,
  output state_e                state_dbg
);

  state_e state_q, state_d;
  logic   stop_seen_q, stop_seen_d;

  logic [4:0]           op;
  logic [REG_IDX_W-1:0] ra, rb, rc, rout_sel;
  logic                 alu_op, muldiv_op, rout_en, rin_en;
  logic                 unused_ir_bits;

  assign op        = IR[OP_MSB:OP_LSB];
  assign ra        = IR[RA_MSB:RA_LSB];
  assign rb        = IR[RB_MSB:RB_LSB];
  assign rc        = IR[RC_MSB:RC_LSB];
  assign alu_op    = is_alu_op(op);
  assign muldiv_op = is_muldiv_op(op);
  assign unused_ir_bits = ^IR[RC_LSB-1:0];
  assign state_dbg = state_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      stop_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_seen_q <= stop_seen_d;
    end
  end

  // A stop seen on the final edge of an instruction still counts for it.
  always_comb begin
    state_d     = state_q;
    stop_seen_d = stop_seen_q | stop;
    case (state_q)
      ST_IDLE: state_d = ST_T0;
      ST_T0:   state_d = ST_T1;
      ST_T1:   state_d = ST_T2;
      ST_T2:   state_d = ST_T3;
      ST_T3: begin
        if (op == OP_HALT)            state_d = ST_HALT;
        else if (alu_op || muldiv_op) state_d = ST_T4;
        else                          state_d = ST_T0;
      end
      ST_T4:   state_d = ST_T5;
      ST_T5: begin
        if (muldiv_op)                 state_d = ST_T6;
        else if (stop_seen_q || stop)  state_d = ST_HALT;
        else                           state_d = ST_T0;
      end
      ST_T6:   state_d = (stop_seen_q || stop) ? ST_HALT : ST_T0;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_T0) stop_seen_d = 1'b0;
  end

  assign rout_en  = (state_q == ST_T3) || (state_q == ST_T4);
  assign rout_sel = (state_q == ST_T4) ? rc : rb;
  assign rin_en   = (state_q == ST_T5) && alu_op;

  reg_field_decoder #(.NUM_OUT(NUM_REGS), .SEL_W(REG_IDX_W)) u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (Rout)
  );

  reg_field_decoder #(.NUM_OUT(NUM_REGS), .SEL_W(REG_IDX_W)) u_rin_dec (
    .en     (rin_en),
    .sel    (ra),
    .onehot (Rin)
  );

  always_comb begin
    PCout   = 1'b0;
    Zlo_out = 1'b0;
    Zhi_out = 1'b0;
    MDRout  = 1'b0;
    MARin   = 1'b0;
    PCin    = 1'b0;
    MDRin   = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    HIin    = 1'b0;
    LOin    = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    opcode  = 5'd0;
    run     = (state_q != ST_IDLE) && (state_q != ST_HALT);
    case (state_q)
      ST_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      ST_T1: begin
        Zlo_out = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      ST_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      ST_T3: Yin = 1'b1;
      ST_T4: begin
        opcode = op;
        Zin    = 1'b1;
      end
      ST_T5: begin
        Zlo_out = 1'b1;
        LOin    = muldiv_op;
      end
      ST_T6: begin
        Zhi_out = 1'b1;
        HIin    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected per-cycle control words are
// queued by the driver and consumed by a negedge monitor; a tiny datapath model checks results.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  typedef struct packed {
    logic [13:0] flags;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  opc;
    logic        run;
  } ctl_t;

  localparam int CW = $bits(ctl_t);

  // Flag bit order matches the concatenation in act below.
  localparam logic [13:0] F_PCOUT = 14'h2000;
  localparam logic [13:0] F_ZLO   = 14'h1000;
  localparam logic [13:0] F_ZHI   = 14'h0800;
  localparam logic [13:0] F_MDROUT= 14'h0400;
  localparam logic [13:0] F_MARIN = 14'h0200;
  localparam logic [13:0] F_PCIN  = 14'h0100;
  localparam logic [13:0] F_MDRIN = 14'h0080;
  localparam logic [13:0] F_IRIN  = 14'h0040;
  localparam logic [13:0] F_YIN   = 14'h0020;
  localparam logic [13:0] F_ZIN   = 14'h0010;
  localparam logic [13:0] F_HIIN  = 14'h0008;
  localparam logic [13:0] F_LOIN  = 14'h0004;
  localparam logic [13:0] F_INCPC = 14'h0002;
  localparam logic [13:0] F_READ  = 14'h0001;

  localparam logic [31:0] IR_AND_R1 = 32'h5091_8000;
  localparam logic [31:0] IR_OR_R1  = 32'h5891_8000;
  localparam logic [31:0] IR_MUL    = 32'h7811_8000;
  localparam logic [31:0] IR_HALT   = 32'hD800_0000;
  localparam logic [31:0] IR_AND_R4 = 32'h5211_8000;

  logic        clock, clear, stop;
  logic [31:0] ir;
  logic        pc_out, zlo_out, zhi_out, mdr_out, mar_in, pc_in, mdr_in, ir_in;
  logic        y_in, z_in, hi_in, lo_in, inc_pc, read, run;
  logic [15:0] rin, rout;
  logic [4:0]  opcode;
  state_e      state_dbg;

  control_sequencer #(.DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .clock(clock), .clear(clear), .IR(ir), .stop(stop),
    .PCout(pc_out), .Zlo_out(zlo_out), .Zhi_out(zhi_out), .MDRout(mdr_out),
    .MARin(mar_in), .PCin(pc_in), .MDRin(mdr_in), .IRin(ir_in),
    .Yin(y_in), .Zin(z_in), .HIin(hi_in), .LOin(lo_in),
    .IncPC(inc_pc), .Read(read), .Rin(rin), .Rout(rout),
    .opcode(opcode), .run(run), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  ctl_t act;
  assign act = {pc_out, zlo_out, zhi_out, mdr_out, mar_in, pc_in, mdr_in, ir_in,
                y_in, z_in, hi_in, lo_in, inc_pc, read, rin, rout, opcode, run};

  // scoreboard
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] exp_v;
  int            errors = 0;
  int            checks = 0;
  int            sample_idx = 0;
  logic          mon_en = 1'b0;
  ctl_t          ctl_s = '0;

  task automatic push(input logic [13:0] f, input logic [15:0] ri, input logic [15:0] ro,
                      input logic [4:0] opc, input logic rn);
    ctl_t c;
    c = '{flags: f, rin: ri, rout: ro, opc: opc, run: rn};
    exp_q.push_back(c);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(14'h0, 16'h0, 16'h0, 5'd0, 1'b0);
  endtask

  task automatic push_fetch();
    push(F_PCOUT | F_MARIN | F_INCPC | F_ZIN, 16'h0, 16'h0, 5'd0, 1'b1);
    push(F_ZLO | F_PCIN | F_READ | F_MDRIN, 16'h0, 16'h0, 5'd0, 1'b1);
    push(F_MDROUT | F_IRIN, 16'h0, 16'h0, 5'd0, 1'b1);
  endtask

  // rb=2, rc=3 for every ALU/mul vector in this bench
  task automatic push_alu(input logic [4:0] opc, input logic [15:0] rin_exp);
    push_fetch();
    push(F_YIN, 16'h0, 16'h0004, 5'd0, 1'b1);
    push(F_ZIN, 16'h0, 16'h0008, opc, 1'b1);
    push(F_ZLO, rin_exp, 16'h0, 5'd0, 1'b1);
  endtask

  task automatic push_mul();
    push_fetch();
    push(F_YIN, 16'h0, 16'h0004, 5'd0, 1'b1);
    push(F_ZIN, 16'h0, 16'h0008, 5'b01111, 1'b1);
    push(F_ZLO | F_LOIN, 16'h0, 16'h0, 5'd0, 1'b1);
    push(F_ZHI | F_HIIN, 16'h0, 16'h0, 5'd0, 1'b1);
  endtask

  task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, a, e);
    end
  endtask

  // monitor: one control word per cycle while enabled
  always @(negedge clock) begin
    ctl_s <= act;
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ctl_extra[%0d] act=%h exp=none", sample_idx, act);
      end else begin
        exp_v = exp_q.pop_front();
        if (act !== exp_v) begin
          errors++;
          $display("FAIL ctl[%0d] act=%h exp=%h", sample_idx, act, exp_v);
        end
      end
      sample_idx++;
    end
  end

  // minimal datapath model driven by the sampled control word
  logic [31:0] dp_r [16] = '{0: 32'h0, 2: 32'h12, 3: 32'h14, default: 32'h0};
  logic [31:0] dp_y = '0, dp_pc = '0, dp_lo = '0, dp_hi = 32'hFFFF_FFFF;
  logic [63:0] dp_z = '0;
  logic [31:0] bus;

  always_comb begin
    bus = '0;
    if (ctl_s.flags[13]) bus = dp_pc;
    if (ctl_s.flags[12]) bus = dp_z[31:0];
    if (ctl_s.flags[11]) bus = dp_z[63:32];
    if (ctl_s.flags[10]) bus = ir;
    for (int i = 0; i < 16; i++) if (ctl_s.rout[i]) bus = dp_r[i];
  end

  always @(posedge clock) begin
    if (ctl_s.flags[5]) dp_y <= bus;
    if (ctl_s.flags[4]) begin
      case (ctl_s.opc)
        5'b01010: dp_z <= {32'h0, dp_y & bus};
        5'b01011: dp_z <= {32'h0, dp_y | bus};
        5'b01111: dp_z <= {32'h0, dp_y} * {32'h0, bus};
        default:  dp_z <= {32'h0, bus + {31'h0, ctl_s.flags[1]}};
      endcase
    end
    if (ctl_s.flags[8]) dp_pc <= bus;
    if (ctl_s.flags[2]) dp_lo <= bus;
    if (ctl_s.flags[3]) dp_hi <= bus;
    for (int i = 0; i < 16; i++) if (ctl_s.rin[i]) dp_r[i] <= bus;
  end

  // driver
  initial begin
    clear = 1'b1;
    stop  = 1'b0;
    ir    = 32'h0;
    @(negedge clock);
    check("reset_outs", {12'h0, act}, 64'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    clear = 1'b0;
    ir = IR_AND_R1;
    push_idle(1);
    push_alu(5'b01010, 16'h0002);
    mon_en = 1'b1;
    repeat (7) @(posedge clock);
    #1;
    check("and_r1", {32'h0, dp_r[1]}, 64'h10);
    check("and_next_t0", {60'h0, state_dbg}, {60'h0, ST_T0});

    ir = IR_OR_R1;
    push_alu(5'b01011, 16'h0002);
    repeat (6) @(posedge clock);
    #1;
    check("or_r1", {32'h0, dp_r[1]}, 64'h16);

    ir = IR_MUL;
    push_mul();
    repeat (7) @(posedge clock);
    #1;
    check("mul_lo", {32'h0, dp_lo}, 64'h168);
    check("mul_hi", {32'h0, dp_hi}, 64'h0);

    ir = IR_AND_R1;
    push_alu(5'b01010, 16'h0002);
    push_idle(3);
    @(posedge clock);
    #1 stop = 1'b1;
    @(posedge clock);
    #1 stop = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    check("stop_and_r1", {32'h0, dp_r[1]}, 64'h10);
    check("stop_halted", {63'h0, run}, 64'h0);

    push_idle(2);
    clear = 1'b1;
    #1;
    check("clear_async", {12'h0, act}, 64'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    clear = 1'b0;
    ir = IR_HALT;
    push_idle(1);
    push_fetch();
    push(F_YIN, 16'h0, 16'h0001, 5'd0, 1'b1);
    push_idle(2);
    repeat (7) @(posedge clock);
    #1;
    check("halt_state", {60'h0, state_dbg}, {60'h0, ST_HALT});

    push_idle(2);
    clear = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    clear = 1'b0;
    ir = IR_AND_R4;
    push_idle(1);
    push_fetch();
    push(F_YIN, 16'h0, 16'h0004, 5'd0, 1'b1);
    repeat (5) @(posedge clock);
    #1;
    check("abort_in_t4", {60'h0, state_dbg}, {60'h0, ST_T4});
    push_idle(2);
    clear = 1'b1;
    #1;
    check("abort_outs", {12'h0, act}, 64'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    check("abort_r4_kept", {32'h0, dp_r[4]}, 64'h0);
    clear = 1'b0;
    push_idle(1);
    push_alu(5'b01010, 16'h0010);
    repeat (7) @(posedge clock);
    #1;
    check("restart_r4", {32'h0, dp_r[4]}, 64'h10);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
